systolic_mmu_array: RTL and testbench

Parametrised, weight-stationary systolic matrix-multiply array of ROWS×COLS signed multiply-accumulate cells. It accepts a weight-load phase followed by a stream of input vectors, and emits one output vector per accepted input vector, computed as OUT[c] = Σ_r IN[r]·W[r][c]. Input skew and output de-skew registers are internal, so the block presents aligned vector interfaces. It sits between the activation buffer and the accumulator/activation stage of the accelerator datapath.

---
 rtl/systolic_mmu_array.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_systolic_mmu_array.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mmu_array.sv
// Weight-stationary ROWS x COLS signed MAC array with internal input skew and output de-skew.
// Define MMU_SATURATE_EN to clamp column sums to ACC_WIDTH; otherwise they wrap. ROWS, COLS >= 2.
module systolic_mmu_array #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ROWS      = 4,
   parameter int unsigned COLS      = 4,
   parameter int unsigned ACC_WIDTH = 16
) (
   input  logic                      CLK,
   input  logic                      SYNC_RST,
   input  logic                      EN,
   input  logic                      W_VALID,
   output logic                      W_READY,
   input  logic [WIDTH*COLS-1:0]     W_DATA,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [WIDTH*ROWS-1:0]     IN_DATA,
   input  logic                      IN_LAST,
   output logic                      OUT_VALID,
   output logic [ACC_WIDTH*COLS-1:0] OUT_DATA,
   output logic                      OUT_LAST,
   output logic                      BUSY
);

   localparam int unsigned ProdW   = 2 * WIDTH;
   localparam int unsigned SumW    = 2 * WIDTH + $clog2(ROWS);
   localparam int unsigned Lat     = ROWS + COLS;
   localparam int unsigned RowCntW = $clog2(ROWS);
   localparam int unsigned DrainW  = $clog2(Lat + 1);

   typedef enum logic [1:0] {StIdle, StLoadW, StCompute, StDrain} state_e;

   state_e               state_q, state_d;
   logic [RowCntW-1:0]   row_cnt_q, row_cnt_d;
   logic [DrainW-1:0]    drain_cnt_q, drain_cnt_d;
   logic                 w_loaded_q, w_loaded_d;
   logic                 w_acc, in_acc;
   logic [RowCntW-1:0]   w_row;

   assign w_acc  = W_VALID & W_READY & EN;
   assign in_acc = IN_VALID & IN_READY & EN;
   assign BUSY   = (state_q != StIdle);

   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         state_q     <= StIdle;
         row_cnt_q   <= '0;
         drain_cnt_q <= '0;
         w_loaded_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         w_loaded_q  <= w_loaded_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      drain_cnt_d = drain_cnt_q;
      w_loaded_d  = w_loaded_q;
      unique case (state_q)
         StIdle: begin
            if (w_acc) begin
               state_d    = StLoadW;
               row_cnt_d  = RowCntW'(1);
               w_loaded_d = 1'b0;
            end else if (in_acc) begin
               // A single-vector stream skips straight to draining.
               if (IN_LAST) begin
                  state_d     = StDrain;
                  drain_cnt_d = DrainW'(Lat);
               end else begin
                  state_d = StCompute;
               end
            end
         end
         StLoadW: begin
            if (w_acc) begin
               if (row_cnt_q == RowCntW'(ROWS - 1)) begin
                  state_d    = StIdle;
                  w_loaded_d = 1'b1;
               end else begin
                  row_cnt_d = row_cnt_q + RowCntW'(1);
               end
            end
         end
         StCompute: begin
            if (in_acc && IN_LAST) begin
               state_d     = StDrain;
               drain_cnt_d = DrainW'(Lat);
            end
         end
         StDrain: begin
            if (EN) begin
               drain_cnt_d = drain_cnt_q - DrainW'(1);
               if (drain_cnt_q == DrainW'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      W_READY  = 1'b0;
      IN_READY = 1'b0;
      unique case (state_q)
         StIdle: begin
            W_READY  = 1'b1;
            IN_READY = w_loaded_q & ~W_VALID;
         end
         StLoadW:   W_READY  = 1'b1;
         StCompute: IN_READY = 1'b1;
         default:   ;
      endcase
      if (SYNC_RST) begin
         W_READY  = 1'b0;
         IN_READY = 1'b0;
      end
   end

   // Weight storage
   logic signed [WIDTH-1:0] w_q [ROWS][COLS];
   logic signed [WIDTH-1:0] w_d [ROWS][COLS];

   assign w_row = (state_q == StLoadW) ? row_cnt_q : '0;

   always_comb begin
      w_d = w_q;
      if (w_acc) begin
         for (int c = 0; c < COLS; c++) w_d[w_row][c] = W_DATA[c*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RST) w_q <= '{default: '0};
      else          w_q <= w_d;
   end

   // Input skew: row r reaches column 0 r cycles after acceptance.
   logic signed [WIDTH-1:0] in_elem [ROWS];
   logic signed [WIDTH-1:0] a_col0  [ROWS];

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         in_elem[r] = in_acc ? $signed(IN_DATA[r*WIDTH +: WIDTH]) : '0;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      if (r == 0) begin : g_direct
         assign a_col0[r] = in_elem[r];
      end else begin : g_delay
         logic signed [WIDTH-1:0] dly_q [r];
         logic signed [WIDTH-1:0] dly_d [r];
         always_comb begin
            dly_d[0] = in_elem[r];
            for (int k = 1; k < r; k++) dly_d[k] = dly_q[k-1];
         end
         always_ff @(posedge CLK) begin
            if (SYNC_RST) dly_q <= '{default: '0};
            else if (EN)  dly_q <= dly_d;
         end
         assign a_col0[r] = dly_q[r-1];
      end
   end

   // MAC cells: activations travel right, partial sums travel down.
   logic signed [WIDTH-1:0] a_in   [ROWS][COLS];
   logic signed [WIDTH-1:0] a_q    [ROWS][COLS-1];
   logic signed [WIDTH-1:0] a_d    [ROWS][COLS-1];
   logic signed [SumW-1:0]  psum_q [ROWS][COLS];
   logic signed [SumW-1:0]  psum_d [ROWS][COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe
         logic signed [ProdW-1:0] prod;
         logic signed [SumW-1:0]  p_in;
         if (c == 0) begin : g_left
            assign a_in[r][c] = a_col0[r];
         end else begin : g_inner
            assign a_in[r][c] = a_q[r][c-1];
         end
         if (c < COLS - 1) begin : g_fwd
            assign a_d[r][c] = a_in[r][c];
         end
         if (r == 0) begin : g_top
            assign p_in = '0;
         end else begin : g_below
            assign p_in = psum_q[r-1][c];
         end
         assign prod         = ProdW'(a_in[r][c]) * ProdW'(w_q[r][c]);
         assign psum_d[r][c] = p_in + SumW'(prod);
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         a_q    <= '{default: '0};
         psum_q <= '{default: '0};
      end else if (EN) begin
         a_q    <= a_d;
         psum_q <= psum_d;
      end
   end

   // Output de-skew: column c waits COLS-1-c cycles so all columns line up.
   logic signed [SumW-1:0] col_sum [COLS];

   for (genvar c = 0; c < COLS; c++) begin : g_dsk
      localparam int unsigned Dly = COLS - 1 - c;
      if (Dly == 0) begin : g_direct
         assign col_sum[c] = psum_q[ROWS-1][c];
      end else begin : g_delay
         logic signed [SumW-1:0] dsk_q [Dly];
         logic signed [SumW-1:0] dsk_d [Dly];
         always_comb begin
            dsk_d[0] = psum_q[ROWS-1][c];
            for (int k = 1; k < Dly; k++) dsk_d[k] = dsk_q[k-1];
         end
         always_ff @(posedge CLK) begin
            if (SYNC_RST) dsk_q <= '{default: '0};
            else if (EN)  dsk_q <= dsk_d;
         end
         assign col_sum[c] = dsk_q[Dly-1];
      end
   end

   function automatic logic [ACC_WIDTH-1:0] reduce_sum(input logic signed [SumW-1:0] s);
`ifdef MMU_SATURATE_EN
      localparam longint SatMax = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
      localparam longint SatMin = -(longint'(1) <<< (ACC_WIDTH - 1));
      if (longint'(s) > SatMax)      return ACC_WIDTH'(SatMax);
      else if (longint'(s) < SatMin) return ACC_WIDTH'(SatMin);
      else                           return ACC_WIDTH'(s);
`else
      return ACC_WIDTH'(s);
`endif
   endfunction

   // Valid/last travel alongside the data; out_* is the final output register stage.
   logic [Lat-2:0]               vld_q, vld_d, last_q, last_d;
   logic                         out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic [ACC_WIDTH*COLS-1:0]    out_data_q, out_data_d;

   always_comb begin
      vld_d      = vld_q;
      last_d     = last_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_data_d = out_data_q;
      if (EN) begin
         vld_d      = {vld_q[Lat-3:0], in_acc};
         last_d     = {last_q[Lat-3:0], in_acc & IN_LAST};
         out_vld_d  = vld_q[Lat-2];
         out_last_d = last_q[Lat-2];
         if (vld_q[Lat-2]) begin
            for (int c = 0; c < COLS; c++) begin
               out_data_d[c*ACC_WIDTH +: ACC_WIDTH] = reduce_sum(col_sum[c]);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         vld_q      <= '0;
         last_q     <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         vld_q      <= vld_d;
         last_q     <= last_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         out_data_q <= out_data_d;
      end
   end

   assign OUT_VALID = out_vld_q & EN;
   assign OUT_LAST  = out_vld_q & out_last_q & EN;
   assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_systolic_mmu_array.sv
// Self-checking bench for systolic_mmu_array (4x4, 8-bit operands, 16-bit outputs).
// Table-driven streams feed a scoreboard; hand sequences cover reset, EN stall and mid-run reset.
module tb_systolic_mmu_array;

   logic        clk = 1'b0;
   logic        rst, en, w_valid, in_valid, in_last;
   logic        w_ready, in_ready, out_valid, out_last, busy;
   logic [31:0] w_data, in_data;
   logic [63:0] out_data;

   always #5 clk = ~clk;

   systolic_mmu_array #(
      .WIDTH    (8),
      .ROWS     (4),
      .COLS     (4),
      .ACC_WIDTH(16)
   ) dut (
      .CLK      (clk),
      .SYNC_RST (rst),
      .EN       (en),
      .W_VALID  (w_valid),
      .W_READY  (w_ready),
      .W_DATA   (w_data),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .IN_DATA  (in_data),
      .IN_LAST  (in_last),
      .OUT_VALID(out_valid),
      .OUT_DATA (out_data),
      .OUT_LAST (out_last),
      .BUSY     (busy)
   );

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned en_idx = 0;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [31:0] en_at;
   } exp_t;

   typedef struct packed {
      logic [1:0]  wsel;
      logic [31:0] din;
      logic        last;
      logic [63:0] dout;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en) en_idx <= en_idx + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Scoreboard consumer
   exp_t e;
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
         end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", out_last, e.last);
            chk("latency", en_idx, e.en_at);
         end
      end
   end

   function automatic logic [31:0] p8(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [63:0] p16(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // sel: 0 identity, 1 all ones, 2 all -128, 3 all zero
   function automatic logic [31:0] wrow(input int sel, input int r);
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < 4; c++) begin
         case (sel)
            0:       v[c*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
            1:       v[c*8 +: 8] = 8'd1;
            2:       v[c*8 +: 8] = 8'h80;
            default: v[c*8 +: 8] = 8'd0;
         endcase
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input int sel);
      for (int r = 0; r < 4; r++) begin
         w_valid = 1'b1;
         w_data  = wrow(sel, r);
         @(negedge clk);
         chk("w_ready_beat", w_ready, 1);
         step();
      end
      w_valid = 1'b0;
   endtask

   task automatic drive_vec(input logic [31:0] d, input logic l, input logic [63:0] want);
      exp_t x;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      chk("in_ready_accept", in_ready, 1);
      x.data  = want;
      x.last  = l;
      x.en_at = en_idx + 8;
      sb.push_back(x);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done     = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1'b1;
         else step();
      end
      chk("idle_busy", busy, 0);
      chk("idle_w_ready", w_ready, 1);
      chk("idle_in_ready", in_ready, 1);
      chk("sb_drained", sb.size(), 0);
      if (done) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   int unsigned c0;
   int          pulses;
   int          seen;
   int          cur;

   initial begin
      tbl[0] = '{2'd0, p8(1, 2, 3, 4), 1'b1, p16(1, 2, 3, 4)};
      tbl[1] = '{2'd1, p8(1, 1, 1, 1), 1'b0, p16(4, 4, 4, 4)};
      tbl[2] = '{2'd1, p8(2, 2, 2, 2), 1'b0, p16(8, 8, 8, 8)};
      tbl[3] = '{2'd1, p8(-3, -3, -3, -3), 1'b1, p16(-12, -12, -12, -12)};
      tbl[4] = '{2'd1, p8(10, -20, 30, -40), 1'b1, p16(-20, -20, -20, -20)};
      tbl[5] = '{2'd1, p8(127, 127, 127, 127), 1'b1, p16(508, 508, 508, 508)};
`ifdef MMU_SATURATE_EN
      tbl[6] = '{2'd2, p8(-128, -128, -128, -128), 1'b1, p16(32767, 32767, 32767, 32767)};
`else
      tbl[6] = '{2'd2, p8(-128, -128, -128, -128), 1'b1, p16(0, 0, 0, 0)};
`endif
      tbl[7] = '{2'd2, p8(1, -1, 0, 2), 1'b1, p16(-256, -256, -256, -256)};

      rst = 1'b1; en = 1'b1; w_valid = 1'b0; w_data = '0;
      in_valid = 1'b1; in_data = p8(1, 2, 3, 4); in_last = 1'b0;

      // Reset behaviour, with IN_VALID held high and no weights loaded
      step();
      step();
      @(negedge clk);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_w_ready", w_ready, 1);
      chk("post_rst_in_ready", in_ready, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_out_valid", out_valid, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_weights_busy", busy, 0);
         chk("no_weights_in_ready", in_ready, 0);
         step();
      end
      in_valid = 1'b0;

      // Table-driven streams
      cur = -1;
      for (int i = 0; i < 8; i++) begin
         if (int'(tbl[i].wsel) != cur) begin
            load_w(int'(tbl[i].wsel));
            cur = int'(tbl[i].wsel);
         end
         drive_vec(tbl[i].din, tbl[i].last, tbl[i].dout);
         if (tbl[i].last) wait_idle();
      end

      // EN low for 3 cycles starting 2 cycles after acceptance
      load_w(1);
      in_valid = 1'b1;
      in_data  = p8(5, 6, 7, 8);
      in_last  = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1);
      c0 = cyc;
      begin
         exp_t x;
         x.data  = p16(26, 26, 26, 26);
         x.last  = 1'b1;
         x.en_at = en_idx + 8;
         sb.push_back(x);
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      pulses   = 0;
      seen     = -1;
      for (int k = 1; k <= 20; k++) begin
         en = !(k >= 2 && k <= 4);
         @(negedge clk);
         if (out_valid === 1'b1) begin
            pulses++;
            seen = int'(cyc - c0);
         end
         step();
      end
      en = 1'b1;
      chk("stall_pulses", pulses, 1);
      chk("stall_latency", seen, 11);
      wait_idle();

      // Reset with two vectors in flight
      load_w(1);
      drive_vec(p8(1, 2, 3, 4), 1'b0, p16(10, 10, 10, 10));
      drive_vec(p8(1, 1, 1, 1), 1'b0, p16(4, 4, 4, 4));
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("compute_in_ready", in_ready, 1);
         chk("compute_busy", busy, 1);
         step();
      end
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_w_ready", w_ready, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      step();
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = p8(9, 9, 9, 9);
      pulses   = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
         if (k == 0) begin
            chk("after_rst_in_ready", in_ready, 0);
            chk("after_rst_busy", busy, 0);
            chk("after_rst_out_data", out_data, 0);
         end
         step();
      end
      in_valid = 1'b0;
      chk("after_rst_pulses", pulses, 0);
      load_w(3);
      drive_vec(p8(7, -3, 100, -128), 1'b1, p16(0, 0, 0, 0));
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
